// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared sizing constants and helpers for the piano keyboard
//                matrix scanner and its column decoder.
//                  NUM_BTN - number of note pushbuttons
//                  NUM_SW  - number of octave DIP switches
//                  SCAN_W  - width of the matrix row index
//                  ROWS    - number of matrix rows
//  Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

    localparam int NUM_BTN = 7;
    localparam int NUM_SW  = 2;
    localparam int SCAN_W  = 3;
    localparam int ROWS    = 8;

    typedef logic [SCAN_W-1:0] scan_t;
    typedef logic [ROWS-1:0]   row_t;
    typedef logic [NUM_BTN-1:0] btn_t;
    typedef logic [NUM_SW-1:0]  sw_t;

    // Active-low one-hot row select for a given row index.
    function automatic row_t row_select(input scan_t s);
        row_select = ~(row_t'(1) << s);
    endfunction

endpackage : piano_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One debounce channel: 2-flop synchroniser, saturating
//                consecutive-difference counter and output flop. The input
//                is only judged in cycles where i_sample is high.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                i_raw    - raw asynchronous input
//                i_sample - sample enable (one frame tick)
//                o_out    - debounced value
//                o_flip   - high in the cycle before o_out changes
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DB_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_sample,
    output logic o_out,
    output logic o_flip
);

    localparam logic [3:0] c_CNT_LAST = 4'(DB_FRAMES - 1);
    localparam logic [3:0] c_CNT_MAX  = 4'hF;

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic       r_out;

    logic w_differ;
    logic w_flip;

    assign w_differ = (r_sync2 != r_out);
    // The last needed differing sample: output takes the synced value now.
    assign w_flip   = i_sample && w_differ && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= 4'd0;
            r_out   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_sample) begin
                if (!w_differ) begin
                    r_cnt <= 4'd0;
                end else if (w_flip) begin
                    r_out <= r_sync2;
                    r_cnt <= 4'd0;
                end else if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign o_out  = r_out;
    assign o_flip = w_flip;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_ctrl
//  Description : Keyboard matrix scanner. A prescaler steps an 8-row scan
//                index every SCAN_DIV cycles and drives an active-low
//                one-hot row select. Each wrap of the scan index produces a
//                frame tick that samples the debounce channels for the note
//                buttons and octave switches.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                btn_raw    - raw note pushbuttons (asynchronous)
//                sw_raw     - raw octave switches (asynchronous)
//                scan       - current row index
//                row        - active-low one-hot row select
//                btn        - debounced buttons
//                sw         - debounced switches
//                frame_tick - one-cycle pulse on scan wrap 7 -> 0
//                btn_evt    - one-cycle pulse in the cycle btn changes
//                sw_evt     - one-cycle pulse in the cycle sw changes
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
    import piano_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [SCAN_W-1:0]  scan,
    output logic [ROWS-1:0]    row,
    output logic [NUM_BTN-1:0] btn,
    output logic [NUM_SW-1:0]  sw,
    output logic               frame_tick,
    output logic               btn_evt,
    output logic               sw_evt
);

    localparam int             c_PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(SCAN_DIV - 1);
    localparam scan_t          c_SCAN_LAST  = scan_t'(ROWS - 1);

    logic [c_PRESC_W-1:0] r_presc;
    scan_t                r_scan;
    row_t                 r_row;
    logic                 r_frame_tick;
    logic                 r_btn_evt;
    logic                 r_sw_evt;

    logic                 w_tc;
    scan_t                w_scan_next;
    logic [NUM_BTN-1:0]   w_btn_flip;
    logic [NUM_SW-1:0]    w_sw_flip;

    assign w_tc        = (r_presc == c_PRESC_LAST);
    assign w_scan_next = r_scan + scan_t'(1);

    // ------------------------------------------------------------------
    // Prescaler, scan index and row select. row is computed from the next
    // scan value so both registers change on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_scan       <= '0;
            r_row        <= row_select(scan_t'(0));
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_tc ? '0 : r_presc + c_PRESC_W'(1);
            r_frame_tick <= w_tc && (r_scan == c_SCAN_LAST);
            if (w_tc) begin
                r_scan <= w_scan_next;
                r_row  <= row_select(w_scan_next);
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce channels, all sampled on the frame tick
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce_bit #(
                .DB_FRAMES (DB_FRAMES)
            ) u_db (
                .clk      (clk),
                .rst      (rst),
                .i_raw    (btn_raw[gi]),
                .i_sample (r_frame_tick),
                .o_out    (btn[gi]),
                .o_flip   (w_btn_flip[gi])
            );
        end : g_btn

        for (genvar gj = 0; gj < NUM_SW; gj++) begin : g_sw
            debounce_bit #(
                .DB_FRAMES (DB_FRAMES)
            ) u_db (
                .clk      (clk),
                .rst      (rst),
                .i_raw    (sw_raw[gj]),
                .i_sample (r_frame_tick),
                .o_out    (sw[gj]),
                .o_flip   (w_sw_flip[gj])
            );
        end : g_sw
    endgenerate

    // Flip strobes lead the output flops by one cycle, so registering their
    // OR lines the event pulse up with the cycle the vector changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_evt <= 1'b0;
            r_sw_evt  <= 1'b0;
        end else begin
            r_btn_evt <= |w_btn_flip;
            r_sw_evt  <= |w_sw_flip;
        end
    end

    assign scan       = r_scan;
    assign row        = r_row;
    assign frame_tick = r_frame_tick;
    assign btn_evt    = r_btn_evt;
    assign sw_evt     = r_sw_evt;

endmodule : matrix_scan_ctrl
`default_nettype wire
